tage_ftq: RTL and testbench

Fetch-target queue between the TAGE predictor and the backend. It captures each fetch-time TAGE prediction together with its PC and its global/path history snapshot. It accepts out-of-order branch resolutions from execute and emits in-order `tage_update_t` packets that drive the predictor's update port. On a mispredict it squashes all younger entries.

---
 rtl/tage_ftq.sv | 174 +++++++++++++++++
 tb/tb_tage_ftq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tage_ftq.sv
// tage_ftq: fetch-target queue holding TAGE predictions until their branches resolve, then emitting in-order update packets.
// Optional feature: define TAGE_FTQ_PERF_EN to enable the retire/mispredict performance counters.
package tage_ftq_pkg;
    typedef struct packed {
        int unsigned VLEN;
        int unsigned histBufferSize;
        int unsigned pathHistBits;
        int unsigned nTagHistoryTables;
    } cfg_t;
    localparam cfg_t cva6_cfg = '{VLEN: 64, histBufferSize: 64, pathHistBits: 16, nTagHistoryTables: 4};
    localparam int unsigned TID_W = $clog2(cva6_cfg.nTagHistoryTables + 1);
    function automatic cfg_t build_config(cfg_t c);
        return c;
    endfunction
    typedef struct packed {
        logic             pred_taken;
        logic             provider_taken;
        logic             alt_taken;
        logic [TID_W-1:0] pred_id;
        logic [TID_W-1:0] alt_id;
        logic             u_is_null;
        logic             pseudo_new_alloc;
    } tage_prediction_t;
    typedef struct packed {
        logic                                  valid;
        logic [cva6_cfg.VLEN-1:0]              pc;
        logic [cva6_cfg.histBufferSize-1:0]    ghist;
        logic [cva6_cfg.pathHistBits-1:0]      phist;
        logic                                  pred_taken;
        logic                                  provider_taken;
        logic                                  alt_taken;
        logic [TID_W-1:0]                      pred_id;
        logic [TID_W-1:0]                      alt_id;
        logic                                  u_is_null;
        logic                                  pseudo_new_alloc;
        logic                                  taken;
        logic                                  mispredict;
    } tage_update_t;
endpackage

module tage_ftq #(
    parameter tage_ftq_pkg::cfg_t CVA6Cfg = tage_ftq_pkg::build_config(tage_ftq_pkg::cva6_cfg),
    parameter int unsigned DEPTH = 8,
    parameter type tage_prediction_t = tage_ftq_pkg::tage_prediction_t,
    parameter type tage_update_t = tage_ftq_pkg::tage_update_t
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic                                push_valid_i,
    output logic                                push_ready_o,
    input  logic [CVA6Cfg.VLEN-1:0]             push_pc_i,
    input  logic [CVA6Cfg.histBufferSize-1:0]   push_ghist_i,
    input  logic [CVA6Cfg.pathHistBits-1:0]     push_phist_i,
    input  tage_prediction_t                    push_pred_i,
    output logic [$clog2(DEPTH)-1:0]            push_idx_o,
    input  logic                                resolve_valid_i,
    input  logic [$clog2(DEPTH)-1:0]            resolve_idx_i,
    input  logic                                resolve_taken_i,
    input  logic                                resolve_mispredict_i,
    output tage_update_t                        tage_update_o,
    output logic [$clog2(DEPTH):0]              count_o,
    output logic [31:0]                         perf_updates_o,
    output logic [31:0]                         perf_mispredicts_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0] head_q, tail_q;
    logic [DEPTH-1:0] valid_q, resolved_q, taken_q, mispred_q;
    logic [CVA6Cfg.VLEN-1:0] pc_q [DEPTH];
    logic [CVA6Cfg.histBufferSize-1:0] ghist_q [DEPTH];
    logic [CVA6Cfg.pathHistBits-1:0] phist_q [DEPTH];
    tage_prediction_t pred_q [DEPTH];
    logic [PW-1:0] head_idx, tail_idx, ridx_rel;
    logic full, push_fire, retire, res_ok, squash;
    tage_update_t pkt;

    assign head_idx = head_q[PW-1:0];
    assign tail_idx = tail_q[PW-1:0];
    assign count_o = tail_q - head_q;
    assign full = count_o == (PW+1)'(DEPTH);
    // A mispredict moves the tail this cycle, so no push may land alongside it.
    assign push_ready_o = !full && !flush_i && !(resolve_valid_i && resolve_mispredict_i);
    assign push_fire = push_valid_i && push_ready_o;
    assign push_idx_o = tail_idx;
    assign retire = valid_q[head_idx] && resolved_q[head_idx];
    assign res_ok = resolve_valid_i && valid_q[resolve_idx_i] && !resolved_q[resolve_idx_i];
    assign squash = res_ok && resolve_mispredict_i;
    assign ridx_rel = resolve_idx_i - head_idx;

    // Assemble the update packet for the head entry.
    always_comb begin
        pkt = '0;
        pkt.valid = 1'b1;
        pkt.pc = pc_q[head_idx];
        pkt.ghist = ghist_q[head_idx];
        pkt.phist = phist_q[head_idx];
        pkt.pred_taken = pred_q[head_idx].pred_taken;
        pkt.provider_taken = pred_q[head_idx].provider_taken;
        pkt.alt_taken = pred_q[head_idx].alt_taken;
        pkt.pred_id = pred_q[head_idx].pred_id;
        pkt.alt_id = pred_q[head_idx].alt_id;
        pkt.u_is_null = pred_q[head_idx].u_is_null;
        pkt.pseudo_new_alloc = pred_q[head_idx].pseudo_new_alloc;
        pkt.taken = taken_q[head_idx];
        pkt.mispredict = mispred_q[head_idx];
    end

    // Pointers, per-entry state and the registered update packet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            valid_q <= '0;
            resolved_q <= '0;
            taken_q <= '0;
            mispred_q <= '0;
            tage_update_o <= '0;
        end else if (flush_i) begin
            head_q <= '0;
            tail_q <= '0;
            valid_q <= '0;
            tage_update_o <= '0;
        end else begin
            tage_update_o <= retire ? pkt : '0;
            if (retire) head_q <= head_q + 1'b1;
            if (push_fire) begin
                valid_q[tail_idx] <= 1'b1;
                resolved_q[tail_idx] <= 1'b0;
                tail_q <= tail_q + 1'b1;
            end
            if (res_ok) begin
                resolved_q[resolve_idx_i] <= 1'b1;
                taken_q[resolve_idx_i] <= resolve_taken_i;
                mispred_q[resolve_idx_i] <= resolve_mispredict_i;
            end
            if (squash) begin
                tail_q <= head_q + (PW+1)'(ridx_rel) + 1'b1;
                for (int i = 0; i < DEPTH; i++)
                    if (PW'(i) - head_idx > ridx_rel) valid_q[i] <= 1'b0;
            end
            if (retire) valid_q[head_idx] <= 1'b0;
        end
    end

    // Payload storage is written on push only and needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            pc_q[tail_idx] <= push_pc_i;
            ghist_q[tail_idx] <= push_ghist_i;
            phist_q[tail_idx] <= push_phist_i;
            pred_q[tail_idx] <= push_pred_i;
        end
    end

`ifdef TAGE_FTQ_PERF_EN
    logic [31:0] upd_q, mis_q;
    // Retire counters survive flush; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_q <= '0;
            mis_q <= '0;
        end else if (retire && !flush_i) begin
            upd_q <= upd_q + 32'd1;
            mis_q <= mis_q + 32'(mispred_q[head_idx]);
        end
    end
    assign perf_updates_o = upd_q;
    assign perf_mispredicts_o = mis_q;
`else
    assign perf_updates_o = '0;
    assign perf_mispredicts_o = '0;
`endif
endmodule

// File: tb/tb_tage_ftq.sv
// tb_tage_ftq: directed and randomized checks of tage_ftq against a queue-based reference model.
module tb_tage_ftq;
    import tage_ftq_pkg::*;
    localparam int DEPTH = 8;
`ifdef TAGE_FTQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
    logic push_valid_i = 1'b0, push_ready_o;
    logic [63:0] push_pc_i = '0, push_ghist_i = '0;
    logic [15:0] push_phist_i = '0;
    tage_prediction_t push_pred_i = '0;
    logic [2:0] push_idx_o;
    logic resolve_valid_i = 1'b0, resolve_taken_i = 1'b0, resolve_mispredict_i = 1'b0;
    logic [2:0] resolve_idx_i = '0;
    tage_update_t tage_update_o;
    logic [3:0] count_o;
    logic [31:0] perf_updates_o, perf_mispredicts_o;

    tage_ftq #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .push_pc_i(push_pc_i), .push_ghist_i(push_ghist_i), .push_phist_i(push_phist_i),
        .push_pred_i(push_pred_i), .push_idx_o(push_idx_o),
        .resolve_valid_i(resolve_valid_i), .resolve_idx_i(resolve_idx_i),
        .resolve_taken_i(resolve_taken_i), .resolve_mispredict_i(resolve_mispredict_i),
        .tage_update_o(tage_update_o), .count_o(count_o),
        .perf_updates_o(perf_updates_o), .perf_mispredicts_o(perf_mispredicts_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int idx;
        bit res;
        tage_update_t pkt;
    } ent_t;

    ent_t q[$];
    int tail_m = 0;
    tage_update_t exp_upd = '0;
    int unsigned perf_u = 0, perf_m = 0;
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        chk("count", 256'(count_o), 256'(q.size()));
        chk("update", 256'(tage_update_o), 256'(exp_upd));
        chk("perf_upd", 256'(perf_updates_o), 256'(PERF ? perf_u : 0));
        chk("perf_mis", 256'(perf_mispredicts_o), 256'(PERF ? perf_m : 0));
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, advance model, check registered outputs.
    task automatic step(input bit pv, input bit rv, input int ri, input bit rt, input bit rm, input bit fl);
        bit ready, fire, ret;
        int pos;
        ent_t e;
        push_valid_i = pv;
        resolve_valid_i = rv;
        resolve_idx_i = 3'(ri);
        resolve_taken_i = rt;
        resolve_mispredict_i = rm;
        flush_i = fl;
        push_pc_i = {$urandom, $urandom};
        push_ghist_i = {$urandom, $urandom};
        push_phist_i = 16'($urandom);
        push_pred_i = $bits(tage_prediction_t)'($urandom);
        #1;
        ready = q.size() < DEPTH && !fl && !(rv && rm);
        fire = pv && ready;
        chk("push_ready", 256'(push_ready_o), 256'(ready));
        chk("push_idx", 256'(push_idx_o), 256'(tail_m));
        if (fl) begin
            q.delete();
            tail_m = 0;
            exp_upd = '0;
        end else begin
            ret = q.size() > 0 && q[0].res;
            exp_upd = ret ? q[0].pkt : '0;
            if (ret) begin
                perf_u++;
                perf_m += q[0].pkt.mispredict;
            end
            pos = -1;
            for (int p = 0; p < q.size(); p++) if (q[p].idx == ri) pos = p;
            if (rv && pos >= 0 && !q[pos].res) begin
                q[pos].res = 1'b1;
                q[pos].pkt.taken = rt;
                q[pos].pkt.mispredict = rm;
                if (rm) begin
                    while (q.size() > pos + 1) void'(q.pop_back());
                    tail_m = (ri + 1) % DEPTH;
                end
            end
            if (ret) void'(q.pop_front());
            if (fire) begin
                e.idx = tail_m;
                e.res = 1'b0;
                e.pkt = '0;
                e.pkt.valid = 1'b1;
                e.pkt.pc = push_pc_i;
                e.pkt.ghist = push_ghist_i;
                e.pkt.phist = push_phist_i;
                e.pkt.pred_taken = push_pred_i.pred_taken;
                e.pkt.provider_taken = push_pred_i.provider_taken;
                e.pkt.alt_taken = push_pred_i.alt_taken;
                e.pkt.pred_id = push_pred_i.pred_id;
                e.pkt.alt_id = push_pred_i.alt_id;
                e.pkt.u_is_null = push_pred_i.u_is_null;
                e.pkt.pseudo_new_alloc = push_pred_i.pseudo_new_alloc;
                q.push_back(e);
                tail_m = (tail_m + 1) % DEPTH;
            end
        end
        @(negedge clk_i);
        chk_state();
        push_valid_i = 1'b0;
        resolve_valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    int unsigned bu, bm;
    int ri;

    initial begin
        repeat (2) @(negedge clk_i);
        chk_state();
        chk("reset_ready", 256'(push_ready_o), 256'(1));
        chk("reset_idx", 256'(push_idx_o), 256'(0));
        rst_ni = 1'b1;

        // In-order retire of out-of-order resolves.
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("no_early_retire", 256'(tage_update_o.valid), 256'(0));
        idle(1);
        chk("first_retire_valid", 256'(tage_update_o.valid), 256'(1));
        idle(1);
        chk("second_retire_taken", 256'(tage_update_o.taken), 256'(1));
        chk("plan1_count", 256'(count_o), 256'(1));
        step(0, 0, 0, 0, 0, 1);

        // Full queue back-pressure.
        for (int k = 0; k < 8; k++) step(1, 0, 0, 0, 0, 0);
        chk("full_not_ready", 256'(push_ready_o), 256'(0));
        step(1, 1, 0, 0, 0, 0);
        idle(1);
        chk("after_retire_ready", 256'(push_ready_o), 256'(1));
        chk("after_retire_count", 256'(count_o), 256'(7));
        step(0, 0, 0, 0, 0, 1);

        // Wrapped squash: entries 6,7,0,1, mispredict on 7.
        for (int k = 0; k < 6; k++) step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 1, k, 0, 0, 0);
        idle(2);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 7, 1, 1, 0);
        chk("squash_count", 256'(count_o), 256'(2));
        chk("squash_idx", 256'(push_idx_o), 256'(0));
        step(0, 0, 0, 0, 0, 1);

        // Push, resolve and flush together.
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 1);
        chk("flush_count", 256'(count_o), 256'(0));
        idle(3);

        // Double resolve keeps the first outcome.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("double_resolve_valid", 256'(tage_update_o.valid), 256'(1));
        chk("double_resolve_taken", 256'(tage_update_o.taken), 256'(1));
        idle(2);

        // Performance counters: five retires, two mispredicted.
        step(0, 0, 0, 0, 0, 1);
        bu = perf_u;
        bm = perf_m;
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 2, 1, 1, 0);
        idle(2);
        for (int k = 0; k < 2; k++) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 3, 0, 0, 0);
        step(0, 1, 4, 0, 1, 0);
        idle(2);
        chk("perf5", 256'(perf_updates_o), 256'(PERF ? bu + 5 : 0));
        chk("perf2", 256'(perf_mispredicts_o), 256'(PERF ? bm + 2 : 0));
        step(0, 0, 0, 0, 0, 1);
        chk("perf_kept_on_flush", 256'(perf_updates_o), 256'(PERF ? bu + 5 : 0));

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            ri = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                 q[$urandom_range(0, q.size() - 1)].idx : $urandom_range(0, DEPTH - 1);
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ri, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
        end

        // Asynchronous reset mid-operation.
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0);
        step(0, 1, q.size() > 0 ? q[0].idx : 0, 1, 0, 0);
        #2 rst_ni = 1'b0;
        #1;
        q.delete();
        tail_m = 0;
        exp_upd = '0;
        perf_u = 0;
        perf_m = 0;
        chk_state();
        chk("async_rst_ready", 256'(push_ready_o), 256'(1));
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
